alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
Pipeline stage that sits in front of the ALU. It accepts a fetched RV32I instruction plus register-file operand values over a valid/ready handshake, and decodes opcode/funct3/funct7 into the 4-bit ALU operation code and the final a/b operands. It presents the result, registered, to the execute stage over a second valid/ready handshake. A 2-entry skid buffer makes in_ready purely registered.

Parameters:
XLEN, 32, datapath width of operands and pc
SHAMT_W, 5, width of shift-amount field used for immediate shifts

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
flush  in  1  discard all held entries (branch/exception redirect)
in_valid  in  1  upstream beat valid
in_ready  out  1  stage can accept a beat
in_instr  in  32  instruction word
in_pc  in  XLEN  pc of instruction
in_rs1_val  in  XLEN  rs1 register value
in_rs2_val  in  XLEN  rs2 register value
out_valid  out  1  decoded beat valid
out_ready  in  1  execute stage accepts
out_a  out  XLEN  ALU operand a
out_b  out  XLEN  ALU operand b
out_alu_op  out  4  ALU operation code
out_funct3  out  3  instr[14:12]
out_funct7  out  7  instr[31:25]
out_opcode  out  7  instr[6:0]
out_rd  out  5  destination register
out_illegal  out  1  unsupported encoding

Behaviour:
- ALU op codes: 0 ADD, 1 SLL, 2 SLT, 3 SLTU, 4 XOR, 5 SRL, 6 OR, 7 AND, 8 SUB, 9 SRA; 10-15 never emitted.
- OP (0110011): a=rs1, b=rs2; funct3 maps 000→ADD/SUB (instr[30]), 001→SLL, 010→SLT, 011→SLTU, 100→XOR, 101→SRL/SRA (instr[30]), 110→OR, 111→AND.
- Legal funct7 for OP: 0000000, or 0100000 only with funct3 000/101. Any other funct7 sets illegal.
- OP-IMM (0010011): a=rs1, b=sign-extended instr[31:20]. SUB is never produced.
- OP-IMM shifts (funct3 001/101): b={zeros, instr[24:20]}. funct7 must be 0000000, or 0100000 only for 101; otherwise illegal.
- LUI (0110111): a=0, b={instr[31:12],12'b0}, op ADD.
- AUIPC (0010111): a=pc, b={instr[31:12],12'b0}, op ADD.
- Any other opcode: illegal=1, op ADD, a=rs1, b=rs2. The beat still flows; it is not dropped.
- Latency: one cycle from in_valid&&in_ready to out_valid when out is empty or draining.
- Skid buffer structure: main register drives outputs; skid register catches a beat accepted while main is held (out_valid&&!out_ready).
- in_ready = !skid_valid (registered-only path).
- Strict in-order delivery: skid contents move to main when main drains. Max 2 beats held.
- Simultaneous accept and drain with skid empty: the new beat loads main directly.
- flush: on the flush cycle, main_valid and skid_valid clear at the next edge. An input beat presented that cycle is not captured. Flush has priority over all handshakes.
- An out_ready during flush is irrelevant: the beat is discarded, not counted as delivered.
- Reset: out_valid=0, all out data=0, out_illegal=0, skid empty, in_ready=1 while and after rst.
- Reset mid-operation: held beats are lost; no partial output.
- Output data is stable while out_valid&&!out_ready.

Decomposition:
- alu_pkg: alu_op_t enum (values above); opcode constants OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC; decoded-beat struct (a, b, alu_op, funct3, funct7, opcode, rd, illegal).
- Sub-module alu_decode: purely combinational instr/pc/rs1/rs2 → decoded struct.
- Top holds only the 2-entry skid logic.

Test Plan:
- add x3,x1,x2 (0x002081B3), rs1=5, rs2=7 → next cycle out_valid=1, alu_op=0, a=5, b=7, rd=3, illegal=0.
- sub (0x402081B3) → alu_op=8. srai x1,x1,4 (0x4040D093), rs1=0x80000000 → alu_op=9, b=4.
- addi x1,x0,-1 (0xFFF00093) → b=0xFFFFFFFF, op 0. lui x5,0x12345 (0x123452B7) → a=0, b=0x12345000. auipc with pc=0x100 → a=0x100.
- Backpressure: 3 back-to-back beats, out_ready=0 for 3 cycles → in_ready drops after 2nd beat held; 3rd stalls; release → beats emerge in order 1, 2, 3, none lost or duplicated.
- Illegal: opcode 0x7F, and OP with funct7=0x20/funct3=001 → illegal=1, op 0, beat delivered normally.
- flush asserted with 2 beats held plus in_valid=1 → next cycle out_valid=0, in_ready=1, flushed beats never appear. rst asserted async mid-stall → out_valid drops immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared types and constants for the ALU issue stage.
package alu_pkg;

  localparam int unsigned DATA_W     = 32;
  localparam int unsigned SHAMT_BITS = 5;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SLL  = 4'd1,
    ALU_SLT  = 4'd2,
    ALU_SLTU = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SRL  = 4'd5,
    ALU_OR   = 4'd6,
    ALU_AND  = 4'd7,
    ALU_SUB  = 4'd8,
    ALU_SRA  = 4'd9
  } alu_op_t;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  // One decoded beat as handed to the execute stage.
  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    alu_op_t           alu_op;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [6:0]        opcode;
    logic [4:0]        rd;
    logic              illegal;
  } dec_beat_t;

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I ALU-class decoder: instruction + operands to decoded beat.
module alu_decode
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = DATA_W,
  parameter int unsigned SHAMT_W = SHAMT_BITS
) (
  input  logic [31:0]   instr,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output dec_beat_t     dec
);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;

  assign opcode = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // Operand selection, op mapping and legality check.
  always_comb begin
    dec         = '0;
    dec.a       = rs1_val;
    dec.b       = rs2_val;
    dec.alu_op  = ALU_ADD;
    dec.funct3  = funct3;
    dec.funct7  = funct7;
    dec.opcode  = opcode;
    dec.rd      = instr[11:7];
    dec.illegal = 1'b0;
    unique case (opcode)
      OPC_OP: begin
        if (funct7 == F7_ALT && !(funct3 == 3'b000 || funct3 == 3'b101)) begin
          dec.illegal = 1'b1;
        end else if (funct7 != F7_BASE && funct7 != F7_ALT) begin
          dec.illegal = 1'b1;
        end
        unique case (funct3)
          3'b000:  dec.alu_op = instr[30] ? ALU_SUB : ALU_ADD;
          3'b001:  dec.alu_op = ALU_SLL;
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101:  dec.alu_op = instr[30] ? ALU_SRA : ALU_SRL;
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
        // An illegal encoding still flows, but always as a plain ADD.
        if (dec.illegal) dec.alu_op = ALU_ADD;
      end
      OPC_OP_IMM: begin
        dec.b = {{(XLEN-12){instr[31]}}, instr[31:20]};
        unique case (funct3)
          3'b000:  dec.alu_op = ALU_ADD;
          3'b001: begin
            dec.b       = XLEN'(instr[20 +: SHAMT_W]);
            dec.alu_op  = ALU_SLL;
            dec.illegal = (funct7 != F7_BASE);
          end
          3'b010:  dec.alu_op = ALU_SLT;
          3'b011:  dec.alu_op = ALU_SLTU;
          3'b100:  dec.alu_op = ALU_XOR;
          3'b101: begin
            dec.b       = XLEN'(instr[20 +: SHAMT_W]);
            dec.alu_op  = instr[30] ? ALU_SRA : ALU_SRL;
            dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
          end
          3'b110:  dec.alu_op = ALU_OR;
          default: dec.alu_op = ALU_AND;
        endcase
        if (dec.illegal) dec.alu_op = ALU_ADD;
      end
      OPC_LUI: begin
        dec.a = '0;
        dec.b = XLEN'({instr[31:12], 12'b0});
      end
      OPC_AUIPC: begin
        dec.a = pc;
        dec.b = XLEN'({instr[31:12], 12'b0});
      end
      default: dec.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode plus a 2-entry skid buffer with a registered in_ready.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = DATA_W,
  parameter int unsigned SHAMT_W = SHAMT_BITS
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_val,
  input  logic [XLEN-1:0] in_rs2_val,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_a,
  output logic [XLEN-1:0] out_b,
  output logic [3:0]      out_alu_op,
  output logic [2:0]      out_funct3,
  output logic [6:0]      out_funct7,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic            out_illegal
);

  dec_beat_t dec;
  dec_beat_t main_q, main_d;
  dec_beat_t skid_q, skid_d;
  logic      main_valid_q, main_valid_d;
  logic      skid_valid_q, skid_valid_d;
  logic      in_ready_q, in_ready_d;
  logic      accept;
  logic      main_free;

  alu_decode #(
    .XLEN    (XLEN),
    .SHAMT_W (SHAMT_W)
  ) u_decode (
    .instr   (in_instr),
    .pc      (in_pc),
    .rs1_val (in_rs1_val),
    .rs2_val (in_rs2_val),
    .dec     (dec)
  );

  assign accept    = in_valid && in_ready_q;
  assign main_free = !main_valid_q || out_ready;

  // Next-state for main/skid entries; flush wins over every handshake.
  always_comb begin
    main_d       = main_q;
    skid_d       = skid_q;
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (main_free) begin
      if (skid_valid_q) begin
        // Older skid beat goes first; in_ready was low so nothing new arrives.
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
    in_ready_d = !skid_valid_d;
  end

  // Stage registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_q       <= '0;
      skid_q       <= '0;
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      main_q       <= main_d;
      skid_q       <= skid_d;
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign out_valid   = main_valid_q;
  assign out_a       = main_q.a;
  assign out_b       = main_q.b;
  assign out_alu_op  = main_q.alu_op;
  assign out_funct3  = main_q.funct3;
  assign out_funct7  = main_q.funct7;
  assign out_opcode  = main_q.opcode;
  assign out_rd      = main_q.rd;
  assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1_val;
  logic [31:0] in_rs2_val;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_a;
  logic [31:0] out_b;
  logic [3:0]  out_alu_op;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic        out_illegal;

  int vectors = 0;
  int errors  = 0;

  alu_issue_stage dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1_val  (in_rs1_val),
    .in_rs2_val  (in_rs2_val),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_a       (out_a),
    .out_b       (out_b),
    .out_alu_op  (out_alu_op),
    .out_funct3  (out_funct3),
    .out_funct7  (out_funct7),
    .out_opcode  (out_opcode),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [31:0] rs1, input logic [31:0] rs2);
    in_valid   = v;
    in_instr   = instr;
    in_pc      = pc;
    in_rs1_val = rs1;
    in_rs2_val = rs2;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step(); step();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready",  32'(in_ready),  32'd1);
    chk("rst_out_a",     out_a,          32'd0);
    chk("rst_out_b",     out_b,          32'd0);
    chk("rst_illegal",   32'(out_illegal), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_in_ready", 32'(in_ready), 32'd1);

    // add x3,x1,x2
    drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk("add_valid",  32'(out_valid),   32'd1);
    chk("add_op",     32'(out_alu_op),  32'd0);
    chk("add_a",      out_a,            32'd5);
    chk("add_b",      out_b,            32'd7);
    chk("add_rd",     32'(out_rd),      32'd3);
    chk("add_ill",    32'(out_illegal), 32'd0);
    chk("add_opcode", 32'(out_opcode),  32'h33);

    // sub x3,x1,x2
    drive(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7);
    step();
    chk("sub_op", 32'(out_alu_op), 32'd8);
    chk("sub_f7", 32'(out_funct7), 32'h20);

    // srai x1,x1,4
    drive(1'b1, 32'h4040D093, 32'h0, 32'h80000000, 32'd0);
    step();
    chk("srai_op", 32'(out_alu_op),  32'd9);
    chk("srai_b",  out_b,            32'd4);
    chk("srai_a",  out_a,            32'h80000000);
    chk("srai_f3", 32'(out_funct3),  32'd5);
    chk("srai_ill", 32'(out_illegal), 32'd0);

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h0, 32'h11, 32'h22);
    step();
    chk("addi_op", 32'(out_alu_op), 32'd0);
    chk("addi_a",  out_a,           32'h11);
    chk("addi_b",  out_b,           32'hFFFFFFFF);

    // lui x5,0x12345
    drive(1'b1, 32'h123452B7, 32'h200, 32'h55, 32'h66);
    step();
    chk("lui_a",  out_a,          32'h0);
    chk("lui_b",  out_b,          32'h12345000);
    chk("lui_rd", 32'(out_rd),    32'd5);
    chk("lui_op", 32'(out_alu_op), 32'd0);

    // auipc x5,0x12345 at pc 0x100
    drive(1'b1, 32'h12345297, 32'h100, 32'h55, 32'h66);
    step();
    chk("auipc_a", out_a, 32'h100);
    chk("auipc_b", out_b, 32'h12345000);

    // Unknown opcode 0x7F flows as illegal ADD with register operands.
    drive(1'b1, 32'h0000007F, 32'h0, 32'd9, 32'd10);
    step();
    chk("opc7f_valid", 32'(out_valid),   32'd1);
    chk("opc7f_ill",   32'(out_illegal), 32'd1);
    chk("opc7f_op",    32'(out_alu_op),  32'd0);
    chk("opc7f_a",     out_a,            32'd9);
    chk("opc7f_b",     out_b,            32'd10);

    // OP with funct7=0x20, funct3=001 is illegal.
    drive(1'b1, 32'h402091B3, 32'h0, 32'd1, 32'd2);
    step();
    chk("sllalt_ill", 32'(out_illegal), 32'd1);
    chk("sllalt_op",  32'(out_alu_op),  32'd0);

    // OP-IMM slli with nonzero funct7 is illegal.
    drive(1'b1, 32'h40409093, 32'h0, 32'd1, 32'd2);
    step();
    chk("slli_bad_ill", 32'(out_illegal), 32'd1);

    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("drain_valid", 32'(out_valid), 32'd0);

    // Backpressure: three beats tagged by addi immediate 1,2,3.
    out_ready = 1'b0;
    drive(1'b1, 32'h00100093, 32'h0, 32'h0, 32'h0);
    step();
    chk("bp1_valid", 32'(out_valid), 32'd1);
    chk("bp1_b",     out_b,          32'd1);
    chk("bp1_ready", 32'(in_ready),  32'd1);
    drive(1'b1, 32'h00200093, 32'h0, 32'h0, 32'h0);
    step();
    chk("bp2_ready", 32'(in_ready), 32'd0);
    chk("bp2_b",     out_b,         32'd1);
    drive(1'b1, 32'h00300093, 32'h0, 32'h0, 32'h0);
    step();
    chk("bp3_ready", 32'(in_ready), 32'd0);
    chk("bp3_b",     out_b,         32'd1);
    out_ready = 1'b1;
    step();
    chk("rel1_b",     out_b,          32'd2);
    chk("rel1_valid", 32'(out_valid), 32'd1);
    chk("rel1_ready", 32'(in_ready),  32'd1);
    step();
    chk("rel2_b",     out_b,          32'd3);
    chk("rel2_valid", 32'(out_valid), 32'd1);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("rel3_valid", 32'(out_valid), 32'd0);

    // Flush with two beats held and a new beat offered.
    out_ready = 1'b0;
    drive(1'b1, 32'h00400093, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h00500093, 32'h0, 32'h0, 32'h0);
    step();
    chk("fl_pre_ready", 32'(in_ready), 32'd0);
    flush = 1'b1; out_ready = 1'b1;
    drive(1'b1, 32'h00700093, 32'h0, 32'h0, 32'h0);
    step();
    chk("fl_valid", 32'(out_valid), 32'd0);
    chk("fl_ready", 32'(in_ready),  32'd1);
    flush = 1'b0;
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    step();
    chk("fl_after_valid", 32'(out_valid), 32'd0);

    // Asynchronous reset in the middle of a stall.
    out_ready = 1'b0;
    drive(1'b1, 32'h00800093, 32'h0, 32'h0, 32'h0);
    step();
    drive(1'b1, 32'h00900093, 32'h0, 32'h0, 32'h0);
    step();
    chk("ar_pre_valid", 32'(out_valid), 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("ar_valid", 32'(out_valid), 32'd0);
    chk("ar_ready", 32'(in_ready),  32'd1);
    chk("ar_b",     out_b,          32'd0);
    drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
    out_ready = 1'b1;
    #1 rst = 1'b0;
    step();
    chk("ar_after_valid", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
